// File: rtl/i2s_tx_fifo_p_pkg.sv
// i2s_tx_fifo_p_pkg: frame size and state types plus Gray/frame helpers for the I2S transmit FIFO
package i2s_tx_fifo_p_pkg;
    typedef enum logic [1:0] {f16bits, f24bits, f32bits} frame_size_t;
    typedef enum logic {IDLE, SHIFT} ser_state_t;
    localparam int GRAY_W = 6;
    function automatic logic [5:0] frame_bits(frame_size_t fs);
        return fs == f16bits ? 6'd16 : fs == f24bits ? 6'd24 : 6'd32;
    endfunction
    function automatic logic [GRAY_W-1:0] bin2gray(logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction
    function automatic logic [GRAY_W-1:0] gray2bin(logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/i2s_tx_fifo_p_if.sv
// i2s_tx_fifo_p_if: bus-side write port of the I2S transmit FIFO
interface i2s_tx_fifo_p_if #(parameter int WIDTH = 32, parameter int ADDR = 3);
    logic             write;
    logic [WIDTH-1:0] din;
    logic             clr_ovf;
    logic             full;
    logic [ADDR:0]    wr_level;
    logic             overflow;
    modport master(output write, din, clr_ovf, input full, wr_level, overflow);
    modport slave(input write, din, clr_ovf, output full, wr_level, overflow);
endinterface

// File: rtl/i2s_tx_fifo_p_ptr_sync.sv
// i2s_tx_fifo_p_ptr_sync: multi-stage synchroniser for a Gray-coded pointer
module i2s_tx_fifo_p_ptr_sync #(
    parameter int W     = 4,
    parameter int NSYNC = 2
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [NSYNC-1:0][W-1:0] chain;
    // shift the pointer through the flop chain into the destination domain
    always_ff @(posedge clk or negedge rst_)
        if (!rst_) chain <= '0;
        else chain <= {chain[NSYNC-2:0], d};
    assign q = chain[NSYNC-1];
endmodule

// File: rtl/i2s_tx_fifo_p.sv
// i2s_tx_fifo_p: dual-clock transmit FIFO feeding an MSB-first I2S serializer
module i2s_tx_fifo_p
    import i2s_tx_fifo_p_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ADDR  = 3,
    parameter int NSYNC = 2
) (
    input  logic                  wclk,
    input  logic                  rst_,
    input  logic                  rclk,
    i2s_tx_fifo_p_if.slave        bus,
    input  logic                  clr_udr,
    input  frame_size_t           frame_size,
    input  logic                  ws_change,
    output logic                  sd,
    output logic                  empty,
    output logic                  underrun
);
    logic [WIDTH-1:0] mem [2**ADDR];
    logic [ADDR:0] wptr, wptr_inc, wgray, wgray_r, wptr_r;
    logic [ADDR:0] rptr, rptr_nxt, rgray, rgray_w, rptr_w;
    logic push, load, sd_nxt, udr_nxt;
    logic [5:0] nbits;
    logic [4:0] cnt, cnt_nxt;
    logic [31:0] word, word_nxt;
    ser_state_t state, state_nxt;

    assign push     = bus.write && !bus.full;
    assign wptr_inc = wptr + (ADDR+1)'(1);
    assign rptr_w   = (ADDR+1)'(gray2bin(6'(rgray_w)));
    assign wptr_r   = (ADDR+1)'(gray2bin(6'(wgray_r)));
    assign bus.full     = wptr == {~rptr_w[ADDR], rptr_w[ADDR-1:0]};
    assign bus.wr_level = wptr - rptr_w;
    assign empty    = rptr == wptr_r;
    assign load     = ws_change && !empty;
    assign nbits    = frame_bits(frame_size);

    i2s_tx_fifo_p_ptr_sync #(.W(ADDR+1), .NSYNC(NSYNC)) u_r2w (.clk(wclk), .rst_(rst_), .d(rgray), .q(rgray_w));
    i2s_tx_fifo_p_ptr_sync #(.W(ADDR+1), .NSYNC(NSYNC)) u_w2r (.clk(rclk), .rst_(rst_), .d(wgray), .q(wgray_r));

    // storage is written only on accepted pushes and never reset
    always_ff @(posedge wclk)
        if (push) mem[wptr[ADDR-1:0]] <= bus.din;

    // write pointer, its Gray copy and the sticky overflow flag (set beats clear)
    always_ff @(posedge wclk or negedge rst_)
        if (!rst_) begin
            wptr <= '0;
            wgray <= '0;
            bus.overflow <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr_inc;
                wgray <= (ADDR+1)'(bin2gray(6'(wptr_inc)));
            end
            bus.overflow <= (bus.write && bus.full) || (bus.overflow && !bus.clr_ovf);
        end

    // next word/bit selection: ws_change loads or pads, otherwise walk down the latched word
    always_comb begin
        state_nxt = state;
        word_nxt  = word;
        cnt_nxt   = cnt;
        rptr_nxt  = rptr;
        sd_nxt    = 1'b0;
        udr_nxt   = (ws_change && empty) || (underrun && !clr_udr);
        if (load) begin
            word_nxt  = mem[rptr[ADDR-1:0]][31:0];
            rptr_nxt  = rptr + (ADDR+1)'(1);
            cnt_nxt   = 5'(nbits - 6'd1);
            sd_nxt    = word_nxt[cnt_nxt];
            state_nxt = SHIFT;
        end else if (ws_change) begin
            state_nxt = IDLE;
        end else if (state == SHIFT) begin
            cnt_nxt   = cnt - 5'd1;
            sd_nxt    = cnt == '0 ? 1'b0 : word[cnt_nxt];
            state_nxt = cnt == '0 ? IDLE : SHIFT;
        end
    end

    // serializer registers advance on the falling bit clock so sd is stable at the rising edge
    always_ff @(negedge rclk or negedge rst_)
        if (!rst_) begin
            state <= IDLE;
            word <= '0;
            cnt <= '0;
            rptr <= '0;
            rgray <= '0;
            sd <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state <= state_nxt;
            word <= word_nxt;
            cnt <= cnt_nxt;
            rptr <= rptr_nxt;
            rgray <= (ADDR+1)'(bin2gray(6'(rptr_nxt)));
            sd <= sd_nxt;
            underrun <= udr_nxt;
        end
endmodule

// File: tb/tb_i2s_tx_fifo_p.sv
// tb_i2s_tx_fifo_p: randomized self-checking bench for the I2S transmit FIFO
module tb_i2s_tx_fifo_p;
    import i2s_tx_fifo_p_pkg::*;

    logic wclk = 0, rclk = 0, rst_ = 1;
    logic clr_udr = 0, ws_change = 0;
    logic sd, empty, underrun;
    frame_size_t frame_size = f16bits;
    int wh = 5, rh = 5;
    int checks = 0, passed = 0;
    logic [31:0] q[$];

    i2s_tx_fifo_p_if #(.WIDTH(32), .ADDR(3)) bus();

    i2s_tx_fifo_p #(.WIDTH(32), .ADDR(3), .NSYNC(2)) dut (
        .wclk(wclk), .rst_(rst_), .rclk(rclk), .bus(bus),
        .clr_udr(clr_udr), .frame_size(frame_size), .ws_change(ws_change),
        .sd(sd), .empty(empty), .underrun(underrun)
    );

    initial forever #(wh) wclk = ~wclk;
    initial forever #(rh) rclk = ~rclk;

    function automatic int nbits_of(frame_size_t fs);
        return fs == f16bits ? 16 : fs == f24bits ? 24 : 32;
    endfunction

    // expected serial stream: the low n bits MSB-first followed by zero padding, cut to ncap bits
    function automatic logic [63:0] model_bits(logic [31:0] w, int n, int ncap);
        logic [63:0] v;
        v = 64'(w) & ((64'd1 << n) - 64'd1);
        return ncap >= n ? v << (ncap - n) : v >> (n - ncap);
    endfunction

    task automatic wait_r(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        @(posedge wclk) #1;
        bus.write = 1;
        bus.din = w;
        @(posedge wclk) #1;
        bus.write = 0;
    endtask

    task automatic half_frame(input frame_size_t fs, input frame_size_t fs_mid, input int ncap, output logic [63:0] cap);
        cap = '0;
        @(posedge rclk) #1;
        frame_size = fs;
        ws_change = 1;
        @(negedge rclk) #1 cap = {cap[62:0], sd};
        @(posedge rclk) #1;
        ws_change = 0;
        frame_size = fs_mid;
        for (int i = 1; i < ncap; i++) begin
            @(negedge rclk) #1 cap = {cap[62:0], sd};
        end
    endtask

    task automatic test_reset();
        #2 rst_ = 0;
        #1;
        checks++; if (sd !== 1'b0) $display("FAIL reset_sd: got %b expected 0", sd); else passed++;
        checks++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b expected 0", bus.full); else passed++;
        checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else passed++;
        checks++; if (bus.wr_level !== 4'd0) $display("FAIL reset_wr_level: got %0d expected 0", bus.wr_level); else passed++;
        checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", bus.overflow); else passed++;
        checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b expected 0", underrun); else passed++;
        repeat (3) @(posedge rclk);
        #2 rst_ = 1;
        wait_r(3);
    endtask

    task automatic test_fill_overflow();
        logic [31:0] w;
        frame_size = f16bits;
        for (int i = 0; i < 8; i++) begin
            w = 32'h0000A5A5 + 32'(i);
            push_word(w);
            q.push_back(w);
            checks++; if (bus.wr_level !== 4'(q.size())) $display("FAIL fill_level%0d: got %0d expected %0d", i, bus.wr_level, q.size()); else passed++;
        end
        checks++; if (bus.full !== (q.size() == 8)) $display("FAIL fill_full: got %b expected 1", bus.full); else passed++;
        push_word(32'hDEADBEEF);
        checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", bus.overflow); else passed++;
        checks++; if (bus.wr_level !== 4'(q.size())) $display("FAIL ovf_level: got %0d expected %0d", bus.wr_level, q.size()); else passed++;
        @(posedge wclk) #1 bus.clr_ovf = 1;
        @(posedge wclk) #1 bus.clr_ovf = 0;
        checks++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", bus.overflow); else passed++;
        @(posedge wclk) #1;
        bus.clr_ovf = 1;
        bus.write = 1;
        bus.din = 32'h0BADF00D;
        @(posedge wclk) #1;
        bus.clr_ovf = 0;
        bus.write = 0;
        checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set_wins: got %b expected 1", bus.overflow); else passed++;
        @(posedge wclk) #1 bus.clr_ovf = 1;
        @(posedge wclk) #1 bus.clr_ovf = 0;
    endtask

    task automatic test_serial_f16();
        logic [63:0] cap, exp;
        int ncap;
        wait_r(8);
        for (int k = 0; k < 8; k++) begin
            ncap = k == 0 ? 24 : 16;
            exp = model_bits(q.pop_front(), 16, ncap);
            half_frame(f16bits, f16bits, ncap, cap);
            checks++; if (cap !== exp) $display("FAIL f16_word%0d: got %0h expected %0h", k, cap, exp); else passed++;
        end
        checks++; if (empty !== (q.size() == 0)) $display("FAIL f16_drained_empty: got %b expected 1", empty); else passed++;
        checks++; if (underrun !== 1'b0) $display("FAIL f16_no_underrun: got %b expected 0", underrun); else passed++;
    endtask

    task automatic test_f24_switch();
        logic [63:0] cap, exp;
        push_word(32'h00C0FFEE);
        q.push_back(32'h00C0FFEE);
        push_word(32'h12345678);
        q.push_back(32'h12345678);
        wait_r(8);
        exp = model_bits(q.pop_front(), 24, 32);
        half_frame(f24bits, f32bits, 32, cap);
        checks++; if (cap !== exp) $display("FAIL f24_midswitch: got %0h expected %0h", cap, exp); else passed++;
        exp = model_bits(q.pop_front(), 32, 32);
        half_frame(f32bits, f32bits, 32, cap);
        checks++; if (cap !== exp) $display("FAIL f32_word: got %0h expected %0h", cap, exp); else passed++;
    endtask

    task automatic test_abort();
        logic [63:0] cap, exp;
        logic [31:0] w;
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            push_word(w);
            q.push_back(w);
        end
        wait_r(8);
        exp = model_bits(q.pop_front(), 32, 9);
        half_frame(f32bits, f32bits, 9, cap);
        checks++; if (cap !== exp) $display("FAIL abort_partial: got %0h expected %0h", cap, exp); else passed++;
        exp = model_bits(q.pop_front(), 24, 24);
        half_frame(f24bits, f24bits, 24, cap);
        checks++; if (cap !== exp) $display("FAIL abort_next: got %0h expected %0h", cap, exp); else passed++;
    endtask

    task automatic test_underrun();
        logic [63:0] cap, exp;
        logic [31:0] w;
        wait_r(2);
        checks++; if (empty !== 1'b1) $display("FAIL udr_empty: got %b expected 1", empty); else passed++;
        half_frame(f16bits, f16bits, 20, cap);
        checks++; if (cap !== 64'd0) $display("FAIL udr_sd_zero: got %0h expected 0", cap); else passed++;
        checks++; if (underrun !== 1'b1) $display("FAIL udr_set: got %b expected 1", underrun); else passed++;
        @(posedge rclk) #1 clr_udr = 1;
        @(posedge rclk) #1 clr_udr = 0;
        checks++; if (underrun !== 1'b0) $display("FAIL udr_clear: got %b expected 0", underrun); else passed++;
        @(posedge rclk) #1;
        clr_udr = 1;
        ws_change = 1;
        @(posedge rclk) #1;
        clr_udr = 0;
        ws_change = 0;
        checks++; if (underrun !== 1'b1) $display("FAIL udr_set_wins: got %b expected 1", underrun); else passed++;
        @(posedge rclk) #1 clr_udr = 1;
        @(posedge rclk) #1 clr_udr = 0;
        w = $urandom;
        push_word(w);
        q.push_back(w);
        wait_r(8);
        exp = model_bits(q.pop_front(), 32, 32);
        half_frame(f32bits, f32bits, 32, cap);
        checks++; if (cap !== exp) $display("FAIL udr_after_word: got %0h expected %0h", cap, exp); else passed++;
        checks++; if (underrun !== 1'b0) $display("FAIL udr_stays_clear: got %b expected 0", underrun); else passed++;
    endtask

    task automatic test_stream(input int whalf, input int rhalf);
        int got, sent, r, n;
        logic [63:0] cap, exp;
        frame_size_t fs;
        got = 0;
        sent = 0;
        wh = whalf;
        rh = rhalf;
        wait_r(4);
        fork
            begin
                for (int c = 0; c < 5000 && sent < 20; c++) begin
                    @(posedge wclk) #1;
                    if (!bus.full) begin
                        bus.din = $urandom;
                        bus.write = 1;
                        q.push_back(bus.din);
                        sent++;
                    end else bus.write = 0;
                end
                @(posedge wclk) #1 bus.write = 0;
            end
            begin
                for (int c = 0; c < 20000 && got < 20; c++) begin
                    @(posedge rclk) #1;
                    if (!empty) begin
                        r = $urandom_range(2);
                        fs = r == 0 ? f16bits : r == 1 ? f24bits : f32bits;
                        n = nbits_of(fs);
                        checks++;
                        if (q.size() == 0) $display("FAIL stream%0d_word%0d: got not-empty expected empty", rhalf, got);
                        else begin
                            exp = model_bits(q.pop_front(), n, n);
                            half_frame(fs, fs, n, cap);
                            if (cap !== exp) $display("FAIL stream%0d_word%0d: got %0h expected %0h", rhalf, got, cap, exp);
                            else passed++;
                        end
                        got++;
                    end
                end
            end
        join
        checks++; if (got !== 20 || sent !== 20) $display("FAIL stream%0d_count: got %0d/%0d expected 20/20", rhalf, got, sent); else passed++;
        checks++; if (bus.overflow !== 1'b0 || underrun !== 1'b0) $display("FAIL stream%0d_flags: got %b%b expected 00", rhalf, bus.overflow, underrun); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] cap, exp;
        for (int i = 0; i < 9; i++) begin
            push_word(32'hFFFFFFFF);
            if (q.size() < 8) q.push_back(32'hFFFFFFFF);
        end
        checks++; if (bus.overflow !== 1'b1) $display("FAIL rmid_ovf: got %b expected 1", bus.overflow); else passed++;
        wait_r(6);
        exp = model_bits(q.pop_front(), 32, 4);
        half_frame(f32bits, f32bits, 4, cap);
        checks++; if (cap !== exp) $display("FAIL rmid_bits: got %0h expected %0h", cap, exp); else passed++;
        #2 rst_ = 0;
        #1;
        q.delete();
        checks++; if (sd !== 1'b0) $display("FAIL rmid_sd: got %b expected 0", sd); else passed++;
        checks++; if (bus.full !== 1'b0) $display("FAIL rmid_full: got %b expected 0", bus.full); else passed++;
        checks++; if (bus.wr_level !== 4'd0) $display("FAIL rmid_level: got %0d expected 0", bus.wr_level); else passed++;
        checks++; if (bus.overflow !== 1'b0) $display("FAIL rmid_ovf_clr: got %b expected 0", bus.overflow); else passed++;
        checks++; if (empty !== 1'b1) $display("FAIL rmid_empty: got %b expected 1", empty); else passed++;
        @(posedge rclk) #2 rst_ = 1;
        wait_r(5);
        checks++; if (empty !== 1'b1) $display("FAIL rmid_empty_after: got %b expected 1", empty); else passed++;
        checks++; if (sd !== 1'b0) $display("FAIL rmid_sd_after: got %b expected 0", sd); else passed++;
    endtask

    initial begin
        bus.write = 0;
        bus.din = '0;
        bus.clr_ovf = 0;
        test_reset();
        test_fill_overflow();
        test_serial_f16();
        test_f24_switch();
        test_abort();
        test_underrun();
        test_stream(5, 15);
        test_stream(35, 5);
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/i2s_tx_fifo_p.md
# i2s_tx_fifo_p

Parametrised dual-clock transmit FIFO and serializer for the I2S transmitter. It accepts parallel audio words from the bus side on `wclk` and shifts them out MSB-first on the serial clock `rclk`, one word per word-select half-frame. It has Gray-coded, synchronised pointers, a runtime-selectable frame size (16/24/32 bits), a write-side fill level, and sticky overflow/underrun flags. It sits between the APB register block and the I2S serial output stage, driven by `ws_tracker`'s `ws_change`.

## Interface
Parameters:
- `WIDTH`, 32: parallel word width; must be ≥ 32.
- `ADDR`, 3: log2 of depth; depth = 2^ADDR entries.
- `NSYNC`, 2: synchroniser stages for each pointer crossing; must be ≥ 2.

Ports:
- `wclk` in 1: write/bus clock.
- `rst_` in 1: reset, asynchronous, active-low; applies to both clock domains.
- `rclk` in 1: serial bit clock (SCK).
- `write` in 1: push `din` on posedge `wclk`.
- `din` in WIDTH: sample, LSB-aligned; bits above the frame size are ignored.
- `clr_ovf` in 1: clears `overflow` (wclk domain).
- `clr_udr` in 1: clears `underrun` (rclk domain).
- `frame_size` in `frame_size_t`: f16bits/f24bits/f32bits.
- `ws_change` in 1: start of a new half-frame (rclk domain).
- `sd` out 1: serial data; changes on negedge `rclk`.
- `full` out 1: wclk domain.
- `empty` out 1: rclk domain.
- `wr_level` out ADDR+1: entries occupied, as seen from the wclk side.
- `overflow` out 1: sticky; a write was attempted while `full`.
- `underrun` out 1: sticky; `ws_change` arrived while `empty`.

## Operation
- Storage: 2^ADDR × WIDTH array. Binary pointers are ADDR+1 bits wide, with the MSB as the wrap bit. Gray copies of both pointers are registered in their own domains.
- Write (posedge `wclk`):
  - If `write && !full`: store `din` at `wptr[ADDR-1:0]` and increment `wptr`.
  - If `write && full`: drop the data, set `overflow`, and leave `wptr` unchanged.
  - `clr_ovf` clears `overflow`. If `clr_ovf` and a new overflow occur in the same cycle, set wins.
- Full / level:
  - Synchronise the Gray read pointer into `wclk` through NSYNC flops, then convert it to binary as `rptr_w`.
  - `full` = (`wptr` == {~`rptr_w`[ADDR], `rptr_w`[ADDR-1:0]}).
  - `wr_level` = `wptr` − `rptr_w`, modulo 2^(ADDR+1).
- Empty: synchronise the Gray write pointer into `rclk` the same way. `empty` = (`rptr` == `wptr_r`).
- Serializer (negedge `rclk`):
  - States: IDLE, SHIFT.
  - On `ws_change` with `!empty`:
    - Latch N = 16/24/32 from `frame_size`.
    - Load the word at `rptr`, increment `rptr`, and set the bit counter to N−1.
    - Drive `sd` = word[N−1] and go to SHIFT.
  - In SHIFT: each negedge, decrement the counter and drive `sd` = word[counter]. After bit 0, drive `sd` = 0 until the next `ws_change` (padding), then return to IDLE.
  - On `ws_change` with `empty`: set `underrun`, drive `sd` = 0 for the whole half-frame, and leave `rptr` unchanged.
  - A `ws_change` during SHIFT aborts the current word. Its remaining bits are lost and the next word is loaded per the rules above.
  - `frame_size` is sampled only at load; a mid-word change has no effect on the current word.
  - `clr_udr` clears `underrun`; set wins over clear.
- Conservative flags: `full` may stay asserted, and `empty` may stay asserted, for up to NSYNC+1 cycles after the opposite side frees or fills an entry. They are never late to assert.

## Timing
- Reset values:
  - `sd` = 0, `full` = 0, `empty` = 1, `wr_level` = 0, `overflow` = 0, `underrun` = 0.
  - Pointers = 0; state = IDLE.
  - The array is not reset.
- Write to `full`/`wr_level`: update on the same posedge `wclk` edge.
- Write to `empty` deassert: 1 `wclk` edge plus NSYNC+1 `rclk` negedges, worst case.
- `ws_change` to first bit: `sd` is valid after the same negedge that samples `ws_change`, so the load-to-MSB latency is 0 cycles.
- Wrap-around: pointers roll from 2^(ADDR+1)−1 to 0. Full and empty are distinguished by the MSB.
- Reset mid-word: `sd` goes to 0 immediately and the state returns to IDLE. Partially shifted words are discarded.

## Structure
- `ctrl_pkg`:
  - Add f24bits to `frame_size_t`.
  - Add function `frame_bits(frame_size_t)` returning 16/24/32.
  - Add functions `bin2gray` and `gray2bin`, parametrised by width through a parameterised class or fixed 6-bit versions.
- Sub-module `ptr_sync #(W, NSYNC)`: an NSYNC-stage flop chain with async reset, instantiated twice (write-to-read and read-to-write).
- Internally, keep the serializer as a separate always_ff block and the write logic as another.

## Test plan
- Reset, then 8 writes of 0x0000A5A5..0x0000A5AC in f16bits mode with ADDR=3 → `full`=1 and `wr_level`=8. A 9th write sets `overflow`=1 and does not change the stored data.
- f16bits, word 0x0000A5A5, pulse `ws_change` → `sd` = 1010_0101_1010_0101 on 16 consecutive negedges, then 0 padding until the next `ws_change`.
- f24bits, word 0x00C0FFEE → 24 bits 0xC0FFEE MSB-first. Switching to f32bits mid-word does not change it; the next word 0x12345678 goes out as 32 bits.
- Empty FIFO, `ws_change` → `underrun`=1 and `sd`=0 for the frame. `clr_udr` clears it. A simultaneous `clr_udr` and underrun leaves it at 1.
- Run 20 words through with `wclk`:`rclk` ratios of 3:1 and 1:7 → bit-exact sequence, no loss, and pointer wrap exercised at least twice.
- Assert `rst_` mid-word → all outputs take their reset values asynchronously, and after release `empty`=1.
